param_dp_memory: RTL and testbench
==================================

Name: param_dp_memory

Overview:
- Parametrised simple-dual-port memory: one write port, one independent read port.
- Next generation of the team's instruction/data memory wrapper. Generalised in width, depth and read latency; adds byte-enables, registered pipelined reads with a valid strobe, and a post-reset clear sequencer.
- Sits between the datapath (fetch or load/store unit) and the memory array. Inferred from behavioural RTL, not a vendor IP core.

Parameters:
- DATA_W, 32: word width in bits; must be a multiple of 8.
- ADDR_W, 9: address width.
- DEPTH, 512: number of words; must satisfy DEPTH <= 2**ADDR_W.
- RD_LAT, 1: read latency in cycles; legal values are 1 or 2.
- CLEAR_ON_RESET, 1: 1 = zero the whole array after reset; 0 = skip clearing.

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- we  in  1  write enable.
- a  in  ADDR_W  write address.
- d  in  DATA_W  write data.
- be  in  DATA_W/8  byte enables; bit i covers d[8i+7:8i].
- re  in  1  read request.
- dpra  in  ADDR_W  read address.
- dpo  out  DATA_W  read data.
- dpo_valid  out  1  one-cycle strobe marking dpo as valid for one read.
- busy  out  1  high while the clear sequencer runs; requests are ignored.

Behaviour:
- Reset (rst_n low, asynchronous):
  - dpo = 0, dpo_valid = 0, all pipeline valid bits = 0, clear counter = 0.
  - busy = 1 if CLEAR_ON_RESET = 1, else 0.
  - Array contents are not reset directly.
- FSM states: CLEAR, READY.
  - CLEAR_ON_RESET = 1: after rst_n deasserts, state is CLEAR.
    - Each cycle, write all-zeros to the address in the counter, then increment the counter.
    - The cycle that writes address DEPTH-1 moves the FSM to READY.
    - CLEAR lasts exactly DEPTH cycles. busy drops on the first READY cycle.
  - CLEAR_ON_RESET = 0: FSM starts in READY. Array contents are undefined.
  - Reset asserted during CLEAR aborts the sequence; it restarts from address 0 after release.
- While busy = 1:
  - we and re are ignored: no array write, no read issued, dpo_valid stays 0.
  - Callers must hold requests off until busy = 0.
- Write (READY):
  - On a clk edge with we = 1, each byte lane with be[i] = 1 is updated; lanes with be[i] = 0 keep their contents.
  - be = 0 leaves the word unchanged.
  - a >= DEPTH: the write is dropped.
- Read (READY):
  - re = 1 at edge N captures dpra.
  - RD_LAT = 1: dpo and dpo_valid = 1 are presented after edge N.
  - RD_LAT = 2: an extra output register stage presents them after edge N+1.
  - Fully pipelined: re may be high every cycle, and each cycle gives one dpo_valid pulse in request order.
  - dpo holds its last value when dpo_valid = 0.
  - dpra >= DEPTH returns dpo = 0 with dpo_valid = 1.
- Simultaneous write and read of the same address in one cycle: default is read-first; dpo returns the pre-write word.
- Writes and reads to different addresses in the same cycle are independent.

Optional Feature:
- Macro: MEM_BYPASS_EN.
- Defined: same-address, same-cycle write and read is write-first. dpo returns the byte-merged new word: lanes with be = 1 take d, others take the old data. The read-latency timing is unchanged.
- Not defined: read-first behaviour as in Behaviour, and no forwarding logic is built.

Test Plan:
1. Clear sequence: DEPTH=512, CLEAR_ON_RESET=1.
   - Release rst_n -> busy = 1 for exactly 512 cycles, then 0.
   - Reads of addresses 0, 255, 511 then return 0x00000000 with dpo_valid.
2. Byte-enable merge:
   - Write 0xAABBCCDD to address 5 with be = 4'b1111, then 0x11223344 with be = 4'b0101.
   - Read address 5 -> 0xAA22CC44.
3. Pipelined reads, RD_LAT=2:
   - Preload addresses 1, 2, 3 with 0x1, 0x2, 0x3; hold re high for 3 cycles with dpra = 1, 2, 3.
   - dpo_valid is high on 3 consecutive cycles starting 2 edges after the first request, giving 0x1, 0x2, 0x3.
4. Same-address collision:
   - Address 7 holds 0x0; write 0xDEADBEEF (be = 4'hF) and read address 7 in the same cycle.
   - Result -> 0x00000000 without MEM_BYPASS_EN, 0xDEADBEEF with it.
5. Reset mid-clear and busy masking:
   - Assert rst_n low at clear count 100 -> dpo_valid = 0 immediately.
   - After release, busy lasts a full 512 cycles.
   - A we pulse during busy (address 3, data 0x55) -> address 3 still reads 0.
6. Out-of-range access: DEPTH=300, ADDR_W=9.
   - Write 0xFFFFFFFF to address 400 -> dropped; no address below 300 changes.
   - Read address 400 -> dpo = 0 with dpo_valid = 1.

Source files
------------

// File: rtl/param_dp_memory.sv
// Simple-dual-port memory: byte-enabled write port, pipelined read port, post-reset clear sequencer.
// Latency: RD_LAT (1 or 2) cycles from re to dpo/dpo_valid; fully pipelined, one result per request.
// Backpressure: none; while busy (clear running) we/re are dropped. Define MEM_BYPASS_EN for write-first collisions.
module param_dp_memory #(
    parameter int DATA_W         = 32,
    parameter int ADDR_W         = 9,
    parameter int DEPTH          = 512,
    parameter int RD_LAT         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                we,
    input  logic [ADDR_W-1:0]   a,
    input  logic [DATA_W-1:0]   d,
    input  logic [DATA_W/8-1:0] be,
    input  logic                re,
    input  logic [ADDR_W-1:0]   dpra,
    output logic [DATA_W-1:0]   dpo,
    output logic                dpo_valid,
    output logic                busy
);
    localparam int                NBYTES    = DATA_W / 8;
    // One extra bit so DEPTH == 2**ADDR_W still compares correctly
    localparam logic [ADDR_W:0]   DEPTH_W   = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic {CLEAR, READY} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];
    logic                wr_ok;
    logic                rd_issue;
    logic                rd_ok;
    logic [DATA_W-1:0]   rd_word;
    logic                rd_vld1;
    logic [DATA_W-1:0]   rd_dat1;

    // State register and clear counter; reset always restarts the clear walk from address 0
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= (CLEAR_ON_RESET != 0) ? CLEAR : READY;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    // Next state: step the counter once per cycle, leave CLEAR on the cycle that writes the last word
    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            CLEAR: begin
                if (clr_cnt == LAST_ADDR) begin
                    state_nxt   = READY;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + ADDR_W'(1);
                end
            end
            default: ;
        endcase
    end

    assign busy     = (state == CLEAR);
    assign wr_ok    = we && !busy && ({1'b0, a} < DEPTH_W);
    assign rd_issue = re && !busy;
    assign rd_ok    = ({1'b0, dpra} < DEPTH_W);

    // Array write port: the clear sequencer owns it while busy, otherwise byte-masked user writes
    always_ff @(posedge clk) begin
        if (busy) begin
            mem[clr_cnt] <= '0;
        end else if (wr_ok) begin
            for (int i = 0; i < NBYTES; i++) begin
                if (be[i]) mem[a][8*i +: 8] <= d[8*i +: 8];
            end
        end
    end

    // Read word select: zero for out-of-range addresses; optional same-cycle forwarding of the merged write
    always_comb begin
        rd_word = '0;
        if (rd_ok) begin
            rd_word = mem[dpra];
`ifdef MEM_BYPASS_EN
            if (wr_ok && (a == dpra)) begin
                for (int i = 0; i < NBYTES; i++) begin
                    if (be[i]) rd_word[8*i +: 8] = d[8*i +: 8];
                end
            end
`endif
        end
    end

    // First read stage: capture the word on every issued read, hold it otherwise
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld1 <= 1'b0;
            rd_dat1 <= '0;
        end else begin
            rd_vld1 <= rd_issue;
            if (rd_issue) rd_dat1 <= rd_word;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic              vld2;
        logic [DATA_W-1:0] dat2;

        // Output stage: re-register stage one, data only moves when a valid result passes
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                vld2 <= 1'b0;
                dat2 <= '0;
            end else begin
                vld2 <= rd_vld1;
                if (rd_vld1) dat2 <= rd_dat1;
            end
        end

        assign dpo       = dat2;
        assign dpo_valid = vld2;
    end else begin : g_lat1
        assign dpo       = rd_dat1;
        assign dpo_valid = rd_vld1;
    end

endmodule

// File: tb/tb_param_dp_memory.sv
// Bench for param_dp_memory: two instances share stimulus (A: 512 words, RD_LAT 1; B: 300 words, RD_LAT 2).
// Latency: expectations come from an array/queue reference model advanced once per clock.
// Backpressure: the model tracks the clear window itself and drops requests made inside it.
module tb_param_dp_memory;
    localparam int DW = 32;
    localparam int AW = 9;
    localparam int DA = 512;
    localparam int DB = 300;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [3:0]    be;
    logic          re;
    logic [AW-1:0] dpra;
    logic [DW-1:0] dpo_a, dpo_b;
    logic          dpo_valid_a, dpo_valid_b, busy_a, busy_b;

    param_dp_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DA), .RD_LAT(1), .CLEAR_ON_RESET(1)) u_a (
        .clk(clk), .rst_n(rst_n), .we(we), .a(a), .d(d), .be(be), .re(re), .dpra(dpra),
        .dpo(dpo_a), .dpo_valid(dpo_valid_a), .busy(busy_a));

    param_dp_memory #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DB), .RD_LAT(2), .CLEAR_ON_RESET(1)) u_b (
        .clk(clk), .rst_n(rst_n), .we(we), .a(a), .d(d), .be(be), .re(re), .dpra(dpra),
        .dpo(dpo_b), .dpo_valid(dpo_valid_b), .busy(busy_b));

    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] mdl_a [DA];
    logic [31:0] mdl_b [DA];
    int          clr_a, clr_b;
    logic        e_va, e_vb, pend_vb;
    logic [31:0] e_da, e_db, pend_db;
    int          errors = 0;
    int          checks = 0;

`ifdef MEM_BYPASS_EN
    localparam logic [31:0] COLL_EXP = 32'hDEADBEEF;
`else
    localparam logic [31:0] COLL_EXP = 32'h0000_0000;
`endif

    function automatic logic [31:0] merge(input logic [31:0] old_w, input logic [31:0] new_w, input logic [3:0] m);
        logic [31:0] r;
        r = old_w;
        for (int i = 0; i < 4; i++) if (m[i]) r[8*i +: 8] = new_w[8*i +: 8];
        return r;
    endfunction

    task automatic model_reset();
        e_va = 1'b0; e_da = '0; e_vb = 1'b0; e_db = '0; pend_vb = 1'b0; pend_db = '0;
        clr_a = DA; clr_b = DB;
    endtask

    task automatic model_zero();
        for (int i = 0; i < DA; i++) begin
            mdl_a[i] = '0;
            mdl_b[i] = '0;
        end
    endtask

    // One clock: drive inputs, advance the model, return #1 after the edge
    task automatic step(input logic w, input logic [8:0] wa, input logic [31:0] wd, input logic [3:0] wbe,
                        input logic r, input logic [8:0] ra);
        logic [31:0] rv_a, rv_b;
        logic        iss_a, iss_b;
        we = w; a = wa; d = wd; be = wbe; re = r; dpra = ra;
        iss_a = r && (clr_a == 0);
        iss_b = r && (clr_b == 0);
        rv_a = (int'(ra) < DA) ? mdl_a[ra] : 32'h0;
        rv_b = (int'(ra) < DB) ? mdl_b[ra] : 32'h0;
`ifdef MEM_BYPASS_EN
        if (w && wa == ra && int'(ra) < DA) rv_a = merge(rv_a, wd, wbe);
        if (w && wa == ra && int'(ra) < DB) rv_b = merge(rv_b, wd, wbe);
`endif
        if (w && clr_a == 0 && int'(wa) < DA) mdl_a[wa] = merge(mdl_a[wa], wd, wbe);
        if (w && clr_b == 0 && int'(wa) < DB) mdl_b[wa] = merge(mdl_b[wa], wd, wbe);
        @(posedge clk); #1;
        e_va = iss_a;
        if (iss_a) e_da = rv_a;
        e_vb = pend_vb;
        if (pend_vb) e_db = pend_db;
        pend_vb = iss_b;
        pend_db = rv_b;
        if (clr_a > 0) clr_a--;
        if (clr_b > 0) clr_b--;
    endtask

    task automatic idle();
        step(1'b0, 9'd0, 32'h0, 4'h0, 1'b0, 9'd0);
    endtask

    task automatic rd(input logic [8:0] ra);
        step(1'b0, 9'd0, 32'h0, 4'h0, 1'b1, ra);
    endtask

    task automatic wr(input logic [8:0] wa, input logic [31:0] wd, input logic [3:0] wbe);
        step(1'b1, wa, wd, wbe, 1'b0, 9'd0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; we = 1'b0; a = '0; d = '0; be = '0; re = 1'b0; dpra = '0;
        model_reset();
        model_zero();
        repeat (3) @(posedge clk);
        #1;
        checks++; if (dpo_a !== 32'h0) begin errors++; $display("FAIL rst_dpo_a: got %h want 0", dpo_a); end
        checks++; if (dpo_valid_a !== 1'b0) begin errors++; $display("FAIL rst_vld_a: got %b want 0", dpo_valid_a); end
        checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_busy_a: got %b want 1", busy_a); end
        checks++; if (dpo_b !== 32'h0) begin errors++; $display("FAIL rst_dpo_b: got %h want 0", dpo_b); end
        checks++; if (dpo_valid_b !== 1'b0) begin errors++; $display("FAIL rst_vld_b: got %b want 0", dpo_valid_b); end
        checks++; if (busy_b !== 1'b1) begin errors++; $display("FAIL rst_busy_b: got %b want 1", busy_b); end
    endtask

    task automatic test_clear();
        int k, ka, kb;
        k = 0; ka = -1; kb = -1;
        rst_n = 1'b1;
        while ((busy_a || busy_b) && k < 2000) begin
            idle();
            k++;
            if (ka < 0 && busy_a === 1'b0) ka = k;
            if (kb < 0 && busy_b === 1'b0) kb = k;
        end
        checks++; if (ka != DA) begin errors++; $display("FAIL clear_len_a: got %0d want %0d", ka, DA); end
        checks++; if (kb != DB) begin errors++; $display("FAIL clear_len_b: got %0d want %0d", kb, DB); end
        rd(9'd0);
        checks++; if (dpo_valid_a !== 1'b1 || dpo_a !== 32'h0) begin errors++; $display("FAIL clear_rd0_a: got %b/%h want 1/0", dpo_valid_a, dpo_a); end
        rd(9'd255);
        checks++; if (dpo_valid_a !== 1'b1 || dpo_a !== 32'h0) begin errors++; $display("FAIL clear_rd255_a: got %b/%h want 1/0", dpo_valid_a, dpo_a); end
        checks++; if (dpo_valid_b !== 1'b1 || dpo_b !== 32'h0) begin errors++; $display("FAIL clear_rd0_b: got %b/%h want 1/0", dpo_valid_b, dpo_b); end
        rd(9'd511);
        checks++; if (dpo_valid_a !== 1'b1 || dpo_a !== 32'h0) begin errors++; $display("FAIL clear_rd511_a: got %b/%h want 1/0", dpo_valid_a, dpo_a); end
        idle();
        checks++; if (dpo_valid_a !== 1'b0) begin errors++; $display("FAIL clear_idle_vld_a: got %b want 0", dpo_valid_a); end
        checks++; if (dpo_valid_b !== 1'b1 || dpo_b !== 32'h0) begin errors++; $display("FAIL clear_rd511_b: got %b/%h want 1/0", dpo_valid_b, dpo_b); end
        idle();
    endtask

    task automatic test_byte_enable();
        wr(9'd5, 32'hAABBCCDD, 4'b1111);
        wr(9'd5, 32'h11223344, 4'b0101);
        wr(9'd5, 32'hFFFFFFFF, 4'b0000);
        rd(9'd5);
        checks++; if (dpo_valid_a !== 1'b1 || dpo_a !== 32'hAA22CC44) begin errors++; $display("FAIL be_merge_a: got %b/%h want 1/aa22cc44", dpo_valid_a, dpo_a); end
        idle();
        checks++; if (dpo_valid_b !== 1'b1 || dpo_b !== 32'hAA22CC44) begin errors++; $display("FAIL be_merge_b: got %b/%h want 1/aa22cc44", dpo_valid_b, dpo_b); end
        checks++; if (dpo_valid_a !== 1'b0 || dpo_a !== 32'hAA22CC44) begin errors++; $display("FAIL be_hold_a: got %b/%h want 0/aa22cc44", dpo_valid_a, dpo_a); end
        idle();
    endtask

    task automatic test_pipeline();
        logic       exp_vb [5];
        logic [2:0] exp_db [5];
        exp_vb = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        exp_db = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd3};
        for (int i = 1; i <= 3; i++) wr(9'(i), 32'(i), 4'hF);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 9'd0, 32'h0, 4'h0, i < 3, 9'(i + 1));
            checks++; if (dpo_valid_b !== exp_vb[i]) begin errors++; $display("FAIL pipe_vld_b[%0d]: got %b want %b", i, dpo_valid_b, exp_vb[i]); end
            if (i > 0) begin
                checks++; if (dpo_b !== 32'(exp_db[i])) begin errors++; $display("FAIL pipe_dat_b[%0d]: got %h want %h", i, dpo_b, 32'(exp_db[i])); end
            end
            checks++; if (dpo_valid_a !== (i < 3) || dpo_a !== ((i < 3) ? 32'(i + 1) : 32'd3)) begin
                errors++; $display("FAIL pipe_a[%0d]: got %b/%h", i, dpo_valid_a, dpo_a);
            end
        end
    endtask

    task automatic test_collision();
        step(1'b1, 9'd7, 32'hDEADBEEF, 4'hF, 1'b1, 9'd7);
        checks++; if (dpo_valid_a !== 1'b1 || dpo_a !== COLL_EXP) begin errors++; $display("FAIL coll_a: got %b/%h want 1/%h", dpo_valid_a, dpo_a, COLL_EXP); end
        idle();
        checks++; if (dpo_valid_b !== 1'b1 || dpo_b !== COLL_EXP) begin errors++; $display("FAIL coll_b: got %b/%h want 1/%h", dpo_valid_b, dpo_b, COLL_EXP); end
        rd(9'd7);
        checks++; if (dpo_a !== 32'hDEADBEEF) begin errors++; $display("FAIL coll_after_a: got %h want deadbeef", dpo_a); end
        idle();
        checks++; if (dpo_b !== 32'hDEADBEEF) begin errors++; $display("FAIL coll_after_b: got %h want deadbeef", dpo_b); end
    endtask

    task automatic test_out_of_range();
        wr(9'd400, 32'hFFFFFFFF, 4'hF);
        wr(9'd300, 32'h12345678, 4'hF);
        rd(9'd400);
        checks++; if (dpo_valid_a !== 1'b1 || dpo_a !== 32'hFFFFFFFF) begin errors++; $display("FAIL oor_in_a: got %b/%h want 1/ffffffff", dpo_valid_a, dpo_a); end
        idle();
        checks++; if (dpo_valid_b !== 1'b1 || dpo_b !== 32'h0) begin errors++; $display("FAIL oor_rd_b: got %b/%h want 1/0", dpo_valid_b, dpo_b); end
        for (int i = 0; i < DB + 2; i++) begin
            step(1'b0, 9'd0, 32'h0, 4'h0, i < DB, 9'(i));
            checks++; if (dpo_valid_b !== e_vb || dpo_b !== e_db) begin
                errors++; $display("FAIL oor_scan_b[%0d]: got %b/%h want %b/%h", i, dpo_valid_b, dpo_b, e_vb, e_db);
            end
        end
    endtask

    task automatic test_random();
        logic        w, r;
        logic [8:0]  wa, ra;
        for (int n = 0; n < 600; n++) begin
            w  = ($urandom_range(0, 1) == 1);
            r  = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 3))
                0:       wa = 9'($urandom_range(0, 511));
                1:       wa = 9'($urandom_range(295, 305));
                default: wa = 9'($urandom_range(0, 15));
            endcase
            ra = ($urandom_range(0, 3) == 0) ? wa : 9'($urandom_range(0, 15));
            if ($urandom_range(0, 7) == 0) ra = 9'($urandom_range(290, 511));
            step(w, wa, 32'($urandom), 4'($urandom_range(0, 15)), r, ra);
            checks++; if (dpo_valid_a !== e_va || dpo_a !== e_da) begin
                errors++; $display("FAIL rand_a[%0d]: got %b/%h want %b/%h", n, dpo_valid_a, dpo_a, e_va, e_da);
            end
            checks++; if (dpo_valid_b !== e_vb || dpo_b !== e_db) begin
                errors++; $display("FAIL rand_b[%0d]: got %b/%h want %b/%h", n, dpo_valid_b, dpo_b, e_vb, e_db);
            end
        end
        idle();
        idle();
    endtask

    task automatic test_reset_mid_clear();
        int k, ka, kb;
        wr(9'd3, 32'h0BADF00D, 4'hF);
        rd(9'd3);
        checks++; if (dpo_valid_a !== 1'b1) begin errors++; $display("FAIL mid_pre_vld_a: got %b want 1", dpo_valid_a); end
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (dpo_valid_a !== 1'b0 || dpo_a !== 32'h0) begin errors++; $display("FAIL mid_async_a: got %b/%h want 0/0", dpo_valid_a, dpo_a); end
        checks++; if (busy_a !== 1'b1 || busy_b !== 1'b1) begin errors++; $display("FAIL mid_async_busy: got %b%b want 11", busy_a, busy_b); end
        @(posedge clk); #1;
        checks++; if (dpo_valid_b !== 1'b0) begin errors++; $display("FAIL mid_killed_b: got %b want 0", dpo_valid_b); end
        rst_n = 1'b1;
        model_zero();
        repeat (100) idle();
        rst_n = 1'b0;
        #1;
        checks++; if (dpo_valid_a !== 1'b0 || busy_a !== 1'b1) begin errors++; $display("FAIL mid_abort_a: got vld %b busy %b want 0 1", dpo_valid_a, busy_a); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        k = 0; ka = -1; kb = -1;
        while ((busy_a || busy_b) && k < 2000) begin
            if (k == 10) step(1'b1, 9'd3, 32'h55, 4'hF, 1'b1, 9'd3);
            else idle();
            k++;
            if (ka < 0 && busy_a === 1'b0) ka = k;
            if (kb < 0 && busy_b === 1'b0) kb = k;
            if (k <= 13) begin
                checks++; if (dpo_valid_a !== 1'b0 || dpo_valid_b !== 1'b0) begin
                    errors++; $display("FAIL mid_busy_vld[%0d]: got %b%b want 00", k, dpo_valid_a, dpo_valid_b);
                end
            end
        end
        checks++; if (ka != DA) begin errors++; $display("FAIL mid_clear_len_a: got %0d want %0d", ka, DA); end
        checks++; if (kb != DB) begin errors++; $display("FAIL mid_clear_len_b: got %0d want %0d", kb, DB); end
        rd(9'd3);
        checks++; if (dpo_valid_a !== 1'b1 || dpo_a !== 32'h0) begin errors++; $display("FAIL mid_masked_a: got %b/%h want 1/0", dpo_valid_a, dpo_a); end
        idle();
        checks++; if (dpo_valid_b !== 1'b1 || dpo_b !== 32'h0) begin errors++; $display("FAIL mid_masked_b: got %b/%h want 1/0", dpo_valid_b, dpo_b); end
    endtask

    initial begin
        test_reset();
        test_clear();
        test_byte_enable();
        test_pipeline();
        test_collision();
        test_out_of_range();
        test_random();
        test_reset_mid_clear();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
